// File: rtl/ddr2_local_pkg.sv
// Shared types and widths for the DDR2 local-interface responder.
// No latency of its own; holds no state and never applies backpressure.
package ddr2_local_pkg;

    localparam int LOCAL_ADDR_W = 25;
    localparam int LOCAL_DATA_W = 32;
    localparam int LOCAL_SIZE_W = 3;
    localparam int LOCAL_BE_W   = 4;

    typedef enum logic [2:0] {
        ST_CALIB,
        ST_IDLE,
        ST_WRITE,
        ST_READ_WAIT,
        ST_READ_DATA
    } state_t;

    // A zero burst size is a master error and is served as a single beat.
    function automatic logic [LOCAL_SIZE_W-1:0] eff_len(input logic [LOCAL_SIZE_W-1:0] size);
        return (size == '0) ? LOCAL_SIZE_W'(1) : size;
    endfunction

endpackage

// File: rtl/ddr2_model_ram.sv
// Single-port word RAM with per-byte write enables and a registered read port.
// Read data appears 1 cycle after an enabled cycle with no byte enables set; never stalls.
module ddr2_model_ram
    import ddr2_local_pkg::*;
#(
    parameter int ADDR_BITS = 10
) (
    input  logic                    clk,
    input  logic                    en,
    input  logic [LOCAL_BE_W-1:0]   we,
    input  logic [ADDR_BITS-1:0]    addr,
    input  logic [LOCAL_DATA_W-1:0] wdata,
    output logic [LOCAL_DATA_W-1:0] rdata
);

    logic [LOCAL_DATA_W-1:0] mem [2**ADDR_BITS];
    logic [LOCAL_DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (en) begin
            for (int i = 0; i < LOCAL_BE_W; i++) begin
                if (we[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
            if (we == '0) begin
                rdata_q <= mem[addr];
            end
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/ddr2_local_responder.sv
// Local-interface target serving burst reads/writes from on-chip RAM after a calibration delay.
// First read beat READ_LATENCY cycles after acceptance; local_ready drops during reads and on injected stalls.
module ddr2_local_responder
    import ddr2_local_pkg::*;
#(
    parameter int ADDR_BITS    = 10,
    parameter int CALIB_CYCLES = 64,
    parameter int READ_LATENCY = 4,
    parameter int STALL_EVERY  = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    output logic                    calib_done,
    output logic                    local_ready,
    input  logic                    local_burstbegin,
    input  logic [LOCAL_ADDR_W-1:0] local_address,
    input  logic [LOCAL_SIZE_W-1:0] local_size,
    input  logic                    local_write_req,
    input  logic [LOCAL_DATA_W-1:0] local_wdata,
    input  logic [LOCAL_BE_W-1:0]   local_be,
    input  logic                    local_read_req,
    output logic                    local_rdata_valid,
    output logic [LOCAL_DATA_W-1:0] local_rdata,
    output logic                    protocol_err
);

    localparam int          PIPE       = READ_LATENCY - 1;
    localparam logic [15:0] CAL_LAST   = 16'(CALIB_CYCLES - 1);
    localparam logic [15:0] STALL_LAST = 16'((STALL_EVERY == 0) ? 0 : STALL_EVERY - 1);
    localparam logic [7:0]  RD_FIRST   = 8'(READ_LATENCY - 1);

    state_t                  state_q, state_d;
    logic                    calib_done_q, calib_done_d;
    logic                    ready_q, ready_d;
    logic                    perr_q, perr_d;
    logic [15:0]             calib_cnt_q, calib_cnt_d;
    logic [15:0]             stall_cnt_q, stall_cnt_d;
    logic [ADDR_BITS-1:0]    addr_q, addr_d;
    logic [LOCAL_SIZE_W-1:0] len_q, len_d;
    logic [LOCAL_SIZE_W-1:0] beat_q, beat_d;
    logic [7:0]              rd_cyc_q, rd_cyc_d;
    logic                    issue_vld_q, issue_vld_d;
    logic [PIPE-1:0]         pipe_vld_q, pipe_vld_d;
    logic [LOCAL_DATA_W-1:0] pipe_dat_q [PIPE];
    logic [LOCAL_DATA_W-1:0] pipe_dat_d [PIPE];

    logic                    ram_en;
    logic [LOCAL_BE_W-1:0]   ram_we;
    logic [ADDR_BITS-1:0]    ram_addr;
    logic [LOCAL_DATA_W-1:0] ram_rdata;
    logic                    wr_acc;
    logic                    rd_cmd;
    logic                    stall_hit;
    logic                    unused_addr_bits;

    assign unused_addr_bits = ^local_address[LOCAL_ADDR_W-1:ADDR_BITS];

    ddr2_model_ram #(
        .ADDR_BITS (ADDR_BITS)
    ) u_ram (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (local_wdata),
        .rdata (ram_rdata)
    );

    always_comb begin
        state_d      = state_q;
        calib_done_d = calib_done_q;
        perr_d       = perr_q;
        calib_cnt_d  = calib_cnt_q;
        addr_d       = addr_q;
        len_d        = len_q;
        beat_d       = beat_q;
        rd_cyc_d     = rd_cyc_q;
        issue_vld_d  = 1'b0;
        ram_en       = 1'b0;
        ram_we       = '0;
        ram_addr     = addr_q + ADDR_BITS'(beat_q);

        wr_acc = ready_q & local_write_req;
        rd_cmd = ready_q & local_read_req & local_burstbegin & ~local_write_req;

        if (STALL_EVERY != 0) begin
            stall_cnt_d = (stall_cnt_q == STALL_LAST) ? 16'd0 : stall_cnt_q + 16'd1;
        end else begin
            stall_cnt_d = 16'd0;
        end
        stall_hit = (STALL_EVERY != 0) && (stall_cnt_d == STALL_LAST);

        case (state_q)
            ST_CALIB: begin
                calib_cnt_d = calib_cnt_q + 16'd1;
                if (local_write_req || local_read_req) begin
                    perr_d = 1'b1;
                end
                if (calib_cnt_q == CAL_LAST) begin
                    state_d      = ST_IDLE;
                    calib_done_d = 1'b1;
                end
            end
            ST_IDLE: begin
                if (wr_acc) begin
                    if (local_burstbegin) begin
                        addr_d   = local_address[ADDR_BITS-1:0];
                        len_d    = eff_len(local_size);
                        beat_d   = LOCAL_SIZE_W'(1);
                        ram_en   = 1'b1;
                        ram_we   = local_be;
                        ram_addr = local_address[ADDR_BITS-1:0];
                        if (local_size == '0 || local_read_req) begin
                            perr_d = 1'b1;
                        end
                        if (eff_len(local_size) != LOCAL_SIZE_W'(1)) begin
                            state_d = ST_WRITE;
                        end
                    end else begin
                        perr_d = 1'b1;
                    end
                end else if (rd_cmd) begin
                    // Beat 0 is fetched right away; the pipeline below supplies the rest of the latency.
                    addr_d      = local_address[ADDR_BITS-1:0];
                    len_d       = eff_len(local_size);
                    beat_d      = LOCAL_SIZE_W'(1);
                    rd_cyc_d    = 8'd1;
                    ram_en      = 1'b1;
                    ram_addr    = local_address[ADDR_BITS-1:0];
                    issue_vld_d = 1'b1;
                    state_d     = ST_READ_WAIT;
                    if (local_size == '0) begin
                        perr_d = 1'b1;
                    end
                end
            end
            ST_WRITE: begin
                if (ready_q && local_read_req) begin
                    perr_d = 1'b1;
                end
                if (wr_acc) begin
                    ram_en = 1'b1;
                    ram_we = local_be;
                    beat_d = beat_q + LOCAL_SIZE_W'(1);
                    if (local_burstbegin) begin
                        perr_d = 1'b1;
                    end
                    if ({1'b0, beat_q} + 4'd1 == {1'b0, len_q}) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_READ_WAIT, ST_READ_DATA: begin
                rd_cyc_d = rd_cyc_q + 8'd1;
                if (beat_q < len_q) begin
                    ram_en      = 1'b1;
                    issue_vld_d = 1'b1;
                    beat_d      = beat_q + LOCAL_SIZE_W'(1);
                end
                if (state_q == ST_READ_WAIT && rd_cyc_q == RD_FIRST) begin
                    state_d = ST_READ_DATA;
                end
                if (state_q == ST_READ_DATA && rd_cyc_q == RD_FIRST + {5'd0, len_q}) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_CALIB;
        endcase

        ready_d = ((state_d == ST_IDLE) || (state_d == ST_WRITE)) && !stall_hit;

        pipe_vld_d[0] = issue_vld_q;
        pipe_dat_d[0] = issue_vld_q ? ram_rdata : '0;
        for (int k = 1; k < PIPE; k++) begin
            pipe_vld_d[k] = pipe_vld_q[k-1];
            pipe_dat_d[k] = pipe_dat_q[k-1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_CALIB;
            calib_done_q <= 1'b0;
            ready_q      <= 1'b0;
            perr_q       <= 1'b0;
            calib_cnt_q  <= 16'd0;
            stall_cnt_q  <= 16'd0;
            addr_q       <= '0;
            len_q        <= '0;
            beat_q       <= '0;
            rd_cyc_q     <= 8'd0;
            issue_vld_q  <= 1'b0;
            pipe_vld_q   <= '0;
            for (int k = 0; k < PIPE; k++) begin
                pipe_dat_q[k] <= '0;
            end
        end else begin
            state_q      <= state_d;
            calib_done_q <= calib_done_d;
            ready_q      <= ready_d;
            perr_q       <= perr_d;
            calib_cnt_q  <= calib_cnt_d;
            stall_cnt_q  <= stall_cnt_d;
            addr_q       <= addr_d;
            len_q        <= len_d;
            beat_q       <= beat_d;
            rd_cyc_q     <= rd_cyc_d;
            issue_vld_q  <= issue_vld_d;
            pipe_vld_q   <= pipe_vld_d;
            for (int k = 0; k < PIPE; k++) begin
                pipe_dat_q[k] <= pipe_dat_d[k];
            end
        end
    end

    assign calib_done        = calib_done_q;
    assign local_ready       = ready_q;
    assign protocol_err      = perr_q;
    assign local_rdata_valid = pipe_vld_q[PIPE-1];
    assign local_rdata       = pipe_dat_q[PIPE-1];

endmodule
